// File: rtl/nn_pkg.sv
// Shared types and defaults for the neural-network weight path.
// Used by weight_load_ctrl and its address generator.
package nn_pkg;

  localparam int N_UNITS_DEF   = 6;
  localparam int N_WEIGHTS_DEF = 4;
  localparam int DATA_W_DEF    = 32;

  typedef logic [DATA_W_DEF-1:0] weight_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/load_addr_gen.sv
// Unit/weight counters for the weight loader.
// Produces the RAM address, held unit/slot selects and the last flag.
module load_addr_gen
  import nn_pkg::*;
#(
  parameter int N_UNITS   = N_UNITS_DEF,
  parameter int N_WEIGHTS = N_WEIGHTS_DEF,
  parameter int ADDR_W    = 8,
  parameter int WIDX_W    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_adv,
  input  logic              i_cap,
  input  logic [ADDR_W-1:0] i_base,
  output logic [ADDR_W-1:0] o_addr,
  output logic [3:0]        o_unit_sel,
  output logic [WIDX_W-1:0] o_weight_idx,
  output logic              o_last
);

  logic [3:0]        r_u;
  logic [WIDX_W-1:0] r_w;
  logic [3:0]        r_unit_sel;
  logic [WIDX_W-1:0] r_weight_idx;
  logic [ADDR_W-1:0] w_off;
  logic              w_w_last;

  assign w_w_last = (r_w == WIDX_W'(N_WEIGHTS - 1));
  assign o_last   = w_w_last
                  && (r_u == 4'(N_UNITS - 1));

  // Offset wraps at the address width on purpose.
  assign w_off  = ADDR_W'(r_u) * ADDR_W'(N_WEIGHTS)
                + ADDR_W'(r_w);
  assign o_addr = i_base + w_off;

  assign o_unit_sel   = r_unit_sel;
  assign o_weight_idx = r_weight_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_u <= '0;
      r_w <= '0;
    end else if (i_clr) begin
      r_u <= '0;
      r_w <= '0;
    end else if (i_adv) begin
      if (w_w_last) begin
        r_w <= '0;
        r_u <= r_u + 4'd1;
      end else begin
        r_w <= r_w + WIDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_unit_sel   <= '0;
      r_weight_idx <= '0;
    end else if (i_cap) begin
      r_unit_sel   <= r_u;
      r_weight_idx <= r_w;
    end
  end

endmodule

// File: rtl/weight_load_ctrl.sv
// Streams unit weights from the weight RAM into the RAM mux.
// WEIGHT_LOAD_CHECKSUM_EN adds a running checksum output.
module weight_load_ctrl
  import nn_pkg::*;
#(
  parameter int N_UNITS   = N_UNITS_DEF,
  parameter int N_WEIGHTS = N_WEIGHTS_DEF,
  parameter int RAM_LAT   = 1,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                         CLOCK,
  input  logic                         RESETn,
  input  logic                         start,
  input  logic                         abort,
  input  logic [ADDR_W-1:0]            base_addr,
  output logic                         ram_rd,
  output logic [ADDR_W-1:0]            ram_addr,
  input  logic [DATA_W-1:0]            ram_out,
  output logic [DATA_W-1:0]            weight,
  output logic [3:0]                   unit_sel,
  output logic [$clog2(N_WEIGHTS)-1:0] weight_idx,
  output logic                         write,
  output logic                         busy,
  output logic                         done
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]            checksum
`endif
);

  localparam int WIDX_W = $clog2(N_WEIGHTS);
  localparam int LAT_W  =
    (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [LAT_W-1:0]  r_lat;
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_weight;
  logic              w_accept;
  logic              w_abort;
  logic              w_lat_end;
  logic              w_cap;
  logic              w_clr;
  logic              w_adv;
  logic              w_last;

  assign w_accept  = (r_state == IDLE)
                   && start && !abort;
  assign w_abort   = (r_state != IDLE) && abort;
  assign w_lat_end = (r_state == WAIT)
                   && (r_lat == '0);
  assign w_cap     = w_lat_end && !abort;
  assign w_clr     = w_accept || w_abort;
  assign w_adv     = (r_state == WRITE);

  load_addr_gen #(
    .N_UNITS   (N_UNITS),
    .N_WEIGHTS (N_WEIGHTS),
    .ADDR_W    (ADDR_W),
    .WIDX_W    (WIDX_W)
  ) u_addr_gen (
    .i_clk        (CLOCK),
    .i_rst_n      (RESETn),
    .i_clr        (w_clr),
    .i_adv        (w_adv),
    .i_cap        (w_cap),
    .i_base       (r_base),
    .o_addr       (ram_addr),
    .o_unit_sel   (unit_sel),
    .o_weight_idx (weight_idx),
    .o_last       (w_last)
  );

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ram_rd = 1'b0;
    write  = 1'b0;
    done   = 1'b0;
    busy   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = READ;
      end
      READ: begin
        ram_rd = 1'b1;
        busy   = 1'b1;
        w_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (r_lat == '0) w_next = WRITE;
      end
      WRITE: begin
        write  = 1'b1;
        busy   = 1'b1;
        w_next = w_last ? DONE : READ;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  // Latency counter runs RAM_LAT-1 down to 0 across WAIT.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      r_lat <= '0;
    end else if (r_state == READ) begin
      r_lat <= LAT_W'(RAM_LAT - 1);
    end else if (r_state == WAIT && r_lat != '0) begin
      r_lat <= r_lat - LAT_W'(1);
    end
  end

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      r_base   <= '0;
      r_weight <= '0;
    end else begin
      if (w_accept) r_base   <= base_addr;
      if (w_cap)    r_weight <= ram_out;
    end
  end

  assign weight = r_weight;

`ifdef WEIGHT_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (r_state == WRITE) begin
      r_checksum <= r_checksum + r_weight;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed scoreboard bench for weight_load_ctrl.
// Exercises RAM_LAT=1 and RAM_LAT=3 instances.
module tb_weight_load_ctrl;

  localparam int NU = 6;
  localparam int NW = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NT = NU * NW;

  typedef struct packed {
    logic [3:0]    u;
    logic [1:0]    i;
    logic [DW-1:0] w;
  } wr_t;

  logic CLOCK  = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  logic          start_0 = 0, abort_0 = 0;
  logic [AW-1:0] base_addr_0 = '0;
  logic          ram_rd_0, write_0, busy_0, done_0;
  logic [AW-1:0] ram_addr_0;
  logic [DW-1:0] ram_out_0 = '0, weight_0;
  logic [3:0]    unit_sel_0;
  logic [1:0]    weight_idx_0;
  logic [DW-1:0] checksum_0;

  logic          start_1 = 0, abort_1 = 0;
  logic [AW-1:0] base_addr_1 = '0;
  logic          ram_rd_1, write_1, busy_1, done_1;
  logic [AW-1:0] ram_addr_1;
  logic [DW-1:0] ram_out_1 = '0, weight_1;
  logic [3:0]    unit_sel_1;
  logic [1:0]    weight_idx_1;
  logic [DW-1:0] checksum_1;

  weight_load_ctrl #(.RAM_LAT(1)) u_dut0 (
    .CLOCK      (CLOCK),
    .RESETn     (RESETn),
    .start      (start_0),
    .abort      (abort_0),
    .base_addr  (base_addr_0),
    .ram_rd     (ram_rd_0),
    .ram_addr   (ram_addr_0),
    .ram_out    (ram_out_0),
    .weight     (weight_0),
    .unit_sel   (unit_sel_0),
    .weight_idx (weight_idx_0),
    .write      (write_0),
    .busy       (busy_0),
    .done       (done_0)
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    ,
    .checksum   (checksum_0)
`endif
  );

  weight_load_ctrl #(.RAM_LAT(3)) u_dut1 (
    .CLOCK      (CLOCK),
    .RESETn     (RESETn),
    .start      (start_1),
    .abort      (abort_1),
    .base_addr  (base_addr_1),
    .ram_rd     (ram_rd_1),
    .ram_addr   (ram_addr_1),
    .ram_out    (ram_out_1),
    .weight     (weight_1),
    .unit_sel   (unit_sel_1),
    .weight_idx (weight_idx_1),
    .write      (write_1),
    .busy       (busy_1),
    .done       (done_1)
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    ,
    .checksum   (checksum_1)
`endif
  );

  // RAM image: address base+k holds k+off.
  logic [AW-1:0] ram_base = '0;
  logic [DW-1:0] ram_off  = '0;

  function automatic logic [DW-1:0] ram_val(
    input logic [AW-1:0] a);
    logic [AW-1:0] k;
    k = a - ram_base;
    return DW'(k) + ram_off;
  endfunction

  always @(posedge CLOCK)
    ram_out_0 <= ram_rd_0 ? ram_val(ram_addr_0)
                          : 32'hDEAD_BEEF;

  logic [DW-1:0] p1a = '0, p1b = '0;
  always @(posedge CLOCK) begin
    p1a       <= ram_rd_1 ? ram_val(ram_addr_1)
                          : 32'hDEAD_BEEF;
    p1b       <= p1a;
    ram_out_1 <= p1b;
  end

  wr_t           qw0[$], qw1[$];
  logic [AW-1:0] qa0[$], qa1[$];
  int            t0[2], rd_cyc[2], nwr[2], ndn[2];
  logic [DW-1:0] cks_exp[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic mon(
    input int            d,
    input int            lat,
    input logic          rd,
    input logic [AW-1:0] addr,
    input logic          wr,
    input logic [3:0]    us,
    input logic [1:0]    wi,
    input logic [DW-1:0] wt,
    input logic          dn,
    input logic          bz,
    input logic [DW-1:0] cks);
    wr_t           e;
    logic [AW-1:0] ea;
    int            n;
    int            rel;
    rel = cyc - t0[d];
    if (rd) begin
      rd_cyc[d] = cyc;
      n = (d == 0) ? qa0.size() : qa1.size();
      chk("rd_pending", 64'(n > 0), 1);
      if (n > 0) begin
        ea = (d == 0) ? qa0.pop_front()
                      : qa1.pop_front();
        chk("ram_addr", 64'(addr), 64'(ea));
      end
    end
    if (wr) begin
      n = (d == 0) ? qw0.size() : qw1.size();
      chk("wr_pending", 64'(n > 0), 1);
      if (n > 0) begin
        e = (d == 0) ? qw0.pop_front()
                     : qw1.pop_front();
        chk("write_data", 64'({us, wi, wt}), 64'(e));
      end
      chk("rd_to_wr", 64'(cyc - rd_cyc[d]),
          64'(lat + 1));
      if (nwr[d] == 0)
        chk("first_wr", 64'(rel), 64'(lat + 2));
      nwr[d]++;
    end
    if (dn) begin
      chk("done_cycle", 64'(rel),
          64'((lat + 2) * NT + 1));
      chk("busy_at_done", 64'(bz), 0);
      n = (d == 0) ? qw0.size() : qw1.size();
      chk("wr_left", 64'(n), 0);
`ifdef WEIGHT_LOAD_CHECKSUM_EN
      chk("checksum_done", 64'(cks), 64'(cks_exp[d]));
`endif
      ndn[d]++;
    end
  endtask

  always @(negedge CLOCK) if (RESETn)
    mon(0, 1, ram_rd_0, ram_addr_0, write_0,
        unit_sel_0, weight_idx_0, weight_0,
        done_0, busy_0, checksum_0);

  always @(negedge CLOCK) if (RESETn)
    mon(1, 3, ram_rd_1, ram_addr_1, write_1,
        unit_sel_1, weight_idx_1, weight_1,
        done_1, busy_1, checksum_1);

  // Push expectations, then pulse start for one cycle.
  task automatic load(input int            d,
                      input logic [AW-1:0] base,
                      input logic [DW-1:0] off,
                      input int            n_wr,
                      input int            n_rd);
    wr_t e;
    ram_base   = base;
    ram_off    = off;
    cks_exp[d] = '0;
    for (int k = 0; k < NT; k++) begin
      if (k < n_rd) begin
        if (d == 0) qa0.push_back(AW'(base + k));
        else        qa1.push_back(AW'(base + k));
      end
      if (k < n_wr) begin
        e.u = 4'(k / NW);
        e.i = 2'(k % NW);
        e.w = DW'(k) + off;
        cks_exp[d] = cks_exp[d] + e.w;
        if (d == 0) qw0.push_back(e);
        else        qw1.push_back(e);
      end
    end
    @(negedge CLOCK);
    nwr[d]    = 0;
    ndn[d]    = 0;
    t0[d]     = cyc;
    rd_cyc[d] = cyc;
    if (d == 0) begin
      start_0 = 1; base_addr_0 = base;
    end else begin
      start_1 = 1; base_addr_1 = base;
    end
    @(negedge CLOCK);
    start_0 = 0; base_addr_0 = 8'hAA;
    start_1 = 0; base_addr_1 = 8'hAA;
    #1;
    chk("busy_after_start",
        64'((d == 0) ? busy_0 : busy_1), 1);
  endtask

  task automatic wait_done(input int d,
                           input int limit);
    int i;
    i = 0;
    while (ndn[d] == 0 && i < limit) begin
      @(negedge CLOCK);
      #1;
      i++;
    end
    chk("done_seen", 64'(ndn[d]), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLOCK);
    #1;
    chk("rst_ram_rd",     64'(ram_rd_0), 0);
    chk("rst_write",      64'(write_0), 0);
    chk("rst_busy",       64'(busy_0), 0);
    chk("rst_done",       64'(done_0), 0);
    chk("rst_unit_sel",   64'(unit_sel_0), 0);
    chk("rst_weight_idx", 64'(weight_idx_0), 0);
    chk("rst_weight",     64'(weight_0), 0);
    chk("rst_ram_addr",   64'(ram_addr_0), 0);
    chk("rst_busy1",      64'(busy_1), 0);
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    chk("rst_checksum",   64'(checksum_0), 0);
`endif
    @(negedge CLOCK);
    RESETn = 1;

    // Base 0x10, RAM_LAT=1.
    load(0, 8'h10, 0, NT, NT);
    wait_done(0, 200);
    chk("wr_count_a", 64'(nwr[0]), NT);
    @(negedge CLOCK);
    #1;
    chk("busy_idle_a", 64'(busy_0), 0);
    chk("done_pulse_a", 64'(done_0), 0);
    chk("hold_unit_a", 64'(unit_sel_0), 5);
    chk("hold_idx_a", 64'(weight_idx_0), 3);
    chk("hold_weight_a", 64'(weight_0), 23);

    // RAM_LAT=3 instance.
    load(1, 8'h00, 0, NT, NT);
    wait_done(1, 300);
    chk("wr_count_b", 64'(nwr[1]), NT);

    // Address wrap.
    load(0, 8'hFE, 0, NT, NT);
    wait_done(0, 200);
    chk("wr_count_c", 64'(nwr[0]), NT);

    // Abort in WAIT of unit 2, weight 1.
    load(0, 8'h10, 0, 9, 10);
    repeat (28) @(negedge CLOCK);
    #1;
    chk("pre_abort_busy", 64'(busy_0), 1);
    chk("pre_abort_unit", 64'(unit_sel_0), 2);
    chk("pre_abort_idx", 64'(weight_idx_0), 0);
    abort_0 = 1;
    @(negedge CLOCK);
    abort_0 = 0;
    #1;
    chk("abort_busy", 64'(busy_0), 0);
    repeat (20) @(negedge CLOCK);
    #1;
    chk("abort_wr_count", 64'(nwr[0]), 9);
    chk("abort_no_done", 64'(ndn[0]), 0);
    chk("abort_rd_left", 64'(qa0.size()), 0);
    load(0, 8'h10, 0, NT, NT);
    wait_done(0, 200);
    chk("wr_count_d", 64'(nwr[0]), NT);

    // Start pulsed mid-load is ignored.
    load(0, 8'h20, 0, NT, NT);
    repeat (19) @(negedge CLOCK);
    start_0     = 1;
    base_addr_0 = 8'h80;
    @(negedge CLOCK);
    start_0 = 0;
    wait_done(0, 200);
    repeat (5) @(negedge CLOCK);
    #1;
    chk("wr_count_e", 64'(nwr[0]), NT);
    chk("single_done_e", 64'(ndn[0]), 1);

    // Weights 1..24; checksum 300 when enabled.
    load(0, 8'h10, 1, NT, NT);
    wait_done(0, 200);
    chk("cks_model", 64'(cks_exp[0]), 300);
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    @(negedge CLOCK);
    #1;
    chk("checksum_hold", 64'(checksum_0), 300);
`endif

    // Reset mid-load.
    load(0, 8'h40, 0, 9, 10);
    repeat (28) @(negedge CLOCK);
    RESETn = 0;
    #1;
    chk("midrst_busy", 64'(busy_0), 0);
    chk("midrst_unit", 64'(unit_sel_0), 0);
    chk("midrst_idx", 64'(weight_idx_0), 0);
    chk("midrst_weight", 64'(weight_0), 0);
    chk("midrst_addr", 64'(ram_addr_0), 0);
    chk("midrst_wr_count", 64'(nwr[0]), 9);
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    chk("midrst_checksum", 64'(checksum_0), 0);
`endif
    qw0.delete();
    qa0.delete();
    @(negedge CLOCK);
    RESETn = 1;
    repeat (2) @(negedge CLOCK);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
